// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster geometry for the timing generator and the drawing controllers.
// Counter origin is the start of sync, so visible pixels sit at hCount 144..783, vCount 35..514.
package vga_timing_pkg;

    localparam int CLK_DIV = 4;

    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;

    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;

    localparam int H_TOTAL     = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int H_VIS_START = H_SYNC + H_BP;
    localparam int H_VIS_END   = H_VIS_START + H_VIS - 1;
    localparam int V_VIS_START = V_SYNC + V_BP;
    localparam int V_VIS_END   = V_VIS_START + V_VIS - 1;

    localparam int COUNT_W = 10;
    typedef logic [COUNT_W-1:0] count_t;

    // Inclusive range test used for the visible-area decode.
    function automatic logic in_span(input count_t c, input count_t lo, input count_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate: tick is the combinational terminal count,
// pix_en is the same event registered so it lines up with counters that advance on tick.
module pixel_tick_div #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic pix_en
);
    import vga_timing_pkg::*;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            pix_en  <= tick;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters plus registered sync, bright and
// frame_tick decodes. Optional frame_tick detection is enabled by defining VGA_FRAME_TICK_EN.
module vga_timing_gen #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int H_VIS   = vga_timing_pkg::H_VIS,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP,
    parameter int V_VIS   = vga_timing_pkg::V_VIS,
    parameter int V_FP    = vga_timing_pkg::V_FP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL     = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int H_VIS_START = H_SYNC + H_BP;
    localparam int H_VIS_END   = H_VIS_START + H_VIS - 1;
    localparam int V_VIS_START = V_SYNC + V_BP;
    localparam int V_VIS_END   = V_VIS_START + V_VIS - 1;

    logic   tick;
    count_t h_next;
    count_t v_next;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .pix_en (pix_en)
    );

    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (tick) begin
            if (hCount == count_t'(H_TOTAL - 1)) begin
                h_next = '0;
                v_next = (vCount == count_t'(V_TOTAL - 1)) ? '0 : vCount + count_t'(1);
            end else begin
                h_next = hCount + count_t'(1);
            end
        end
    end

    // Decodes are taken from the next-state counts so they register on the same edge as the counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hCount <= '0;
            vCount <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else begin
            hCount <= h_next;
            vCount <= v_next;
            hSync  <= (h_next >= count_t'(H_SYNC));
            vSync  <= (v_next >= count_t'(V_SYNC));
            bright <= in_span(h_next, count_t'(H_VIS_START), count_t'(H_VIS_END)) &&
                      in_span(v_next, count_t'(V_VIS_START), count_t'(V_VIS_END));
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Fires once per frame as the raster enters the first vertical front-porch line.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick && (h_next == '0) && (v_next == count_t'(V_VIS_END + 1));
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken-geometry
// instance for frame-level timing, checked against a formula model, a hand vector table and sequences.
module tb_vga_timing_gen;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       f_pe, f_hs, f_vs, f_br, f_ft;
    logic [9:0] f_h, f_v;
    logic       s_pe, s_hs, s_vs, s_br, s_ft;
    logic [9:0] s_h, s_v;

    vga_timing_gen u_full (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (f_pe),
        .hCount     (f_h),
        .vCount     (f_v),
        .hSync      (f_hs),
        .vSync      (f_vs),
        .bright     (f_br),
        .frame_tick (f_ft)
    );

    // Small raster: 32 pixels x 13 lines, visible h 12..27, v 5..10, frame = 1664 clk.
    vga_timing_gen #(
        .CLK_DIV (4),
        .H_SYNC  (8),
        .H_BP    (4),
        .H_VIS   (16),
        .H_FP    (4),
        .V_SYNC  (2),
        .V_BP    (3),
        .V_VIS   (6),
        .V_FP    (2)
    ) u_small (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (s_pe),
        .hCount     (s_h),
        .vCount     (s_v),
        .hSync      (s_hs),
        .vSync      (s_vs),
        .bright     (s_br),
        .frame_tick (s_ft)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int n = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          idx;
        logic [24:0] val;
    } sb_t;

    sb_t sb_full[$];
    sb_t sb_small[$];

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input int e, input logic [24:0] act, input logic [24:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s edge %0d: got h=%0d v=%0d hs/vs/br/pe/ft=%b, want h=%0d v=%0d hs/vs/br/pe/ft=%b",
                     nm, e, act[24:15], act[14:5], act[4:0], req[24:15], req[14:5], req[4:0]);
        end
    endtask

    // Expected outputs n edges after reset release, from raster arithmetic.
    function automatic logic [24:0] model(input int nn, input bit in_rst,
                                          input int hsl, input int hbp, input int hvis, input int hfp,
                                          input int vsl, input int vbp, input int vvis, input int vfp);
        int   ht, vt, p, h, v;
        logic pe, hs, vs, br, ft;
        if (in_rst) return '0;
        ht = hsl + hbp + hvis + hfp;
        vt = vsl + vbp + vvis + vfp;
        p  = nn / DIV;
        h  = p % ht;
        v  = (p / ht) % vt;
        pe = (nn > 0) && (nn % DIV == 0);
        hs = (h >= hsl);
        vs = (v >= vsl);
        br = (h >= hsl + hbp) && (h < hsl + hbp + hvis) && (v >= vsl + vbp) && (v < vsl + vbp + vvis);
        ft = 1'b0;
`ifdef VGA_FRAME_TICK_EN
        ft = pe && (h == 0) && (v == vsl + vbp + vvis);
`endif
        return {10'(h), 10'(v), hs, vs, br, pe, ft};
    endfunction

    // Drive rst for the next edge, queue what each DUT must show after it, then pass the edge.
    task automatic step(input logic r);
        sb_t e;
        bit  in_rst;
        rst = r;
        if (r) begin
            n = 0;
            in_rst = 1'b1;
        end else begin
            n++;
            in_rst = 1'b0;
        end
        e.idx = edge_cnt + 1;
        e.val = model(n, in_rst, 96, 48, 640, 16, 2, 33, 480, 10);
        sb_full.push_back(e);
        e.val = model(n, in_rst, 8, 4, 16, 4, 2, 3, 6, 2);
        sb_small.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin : scoreboard
        sb_t e;
        while (sb_full.size() > 0 && sb_full[0].idx <= edge_cnt) begin
            e = sb_full.pop_front();
            chk_vec("sb_full", e.idx, {f_h, f_v, f_hs, f_vs, f_br, f_pe, f_ft}, e.val);
        end
        while (sb_small.size() > 0 && sb_small[0].idx <= edge_cnt) begin
            e = sb_small.pop_front();
            chk_vec("sb_small", e.idx, {s_h, s_v, s_hs, s_vs, s_br, s_pe, s_ft}, e.val);
        end
    end

    typedef struct {
        int sel;   // 0 = full-size instance, 1 = small instance
        int n;
        int h, v, hs, vs, br, pe;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    initial begin : main
        int hs_low, pe_cnt, pe_dbl, br_cnt, vs_low, ft_cnt, ft_first, ft_last;
        logic prev_pe;

        tbl[0]  = '{0, 0,    0,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 3,    0,   0, 0, 0, 0, 0};
        tbl[2]  = '{0, 4,    1,   0, 0, 0, 0, 1};
        tbl[3]  = '{0, 5,    1,   0, 0, 0, 0, 0};
        tbl[4]  = '{0, 383,  95,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 384,  96,  0, 1, 0, 0, 1};
        tbl[6]  = '{1, 560,  12,  4, 1, 1, 0, 1};
        tbl[7]  = '{0, 576,  144, 0, 1, 0, 0, 1};
        tbl[8]  = '{1, 684,  11,  5, 1, 1, 0, 1};
        tbl[9]  = '{1, 688,  12,  5, 1, 1, 1, 1};
        tbl[10] = '{1, 752,  28,  5, 1, 1, 0, 1};
        tbl[11] = '{1, 1388, 27,  10, 1, 1, 1, 1};
        tbl[12] = '{1, 1456, 12,  11, 1, 1, 0, 1};
        tbl[13] = '{0, 3196, 799, 0, 1, 0, 0, 1};
        tbl[14] = '{0, 3199, 799, 0, 1, 0, 0, 0};
        tbl[15] = '{0, 3200, 0,   1, 0, 0, 0, 1};
        tbl[16] = '{0, 6399, 799, 1, 1, 0, 0, 0};
        tbl[17] = '{0, 6400, 0,   2, 0, 1, 0, 1};

        step(1'b1);
        step(1'b1);
        step(1'b1);

        for (int i = 0; i < NV; i++) begin
            while (n < tbl[i].n) step(1'b0);
            if (tbl[i].sel == 0) begin
                chk($sformatf("vec%0d.h", i),  int'(f_h),  tbl[i].h);
                chk($sformatf("vec%0d.v", i),  int'(f_v),  tbl[i].v);
                chk($sformatf("vec%0d.hs", i), int'(f_hs), tbl[i].hs);
                chk($sformatf("vec%0d.vs", i), int'(f_vs), tbl[i].vs);
                chk($sformatf("vec%0d.br", i), int'(f_br), tbl[i].br);
                chk($sformatf("vec%0d.pe", i), int'(f_pe), tbl[i].pe);
            end else begin
                chk($sformatf("vec%0d.h", i),  int'(s_h),  tbl[i].h);
                chk($sformatf("vec%0d.v", i),  int'(s_v),  tbl[i].v);
                chk($sformatf("vec%0d.hs", i), int'(s_hs), tbl[i].hs);
                chk($sformatf("vec%0d.vs", i), int'(s_vs), tbl[i].vs);
                chk($sformatf("vec%0d.br", i), int'(s_br), tbl[i].br);
                chk($sformatf("vec%0d.pe", i), int'(s_pe), tbl[i].pe);
            end
        end

        // One full line on the full-size raster: sync width and strobe spacing.
        hs_low = 0;
        pe_cnt = 0;
        pe_dbl = 0;
        prev_pe = f_pe;
        for (int i = 0; i < 3200; i++) begin
            step(1'b0);
            if (!f_hs) hs_low++;
            if (f_pe) pe_cnt++;
            if (f_pe && prev_pe) pe_dbl++;
            prev_pe = f_pe;
        end
        chk("line_hsync_low_clks", hs_low, 384);
        chk("line_pix_en_count", pe_cnt, 800);
        chk("line_pix_en_back_to_back", pe_dbl, 0);

        // Two full frames on the small raster.
        while (n % 1664 != 0) step(1'b0);
        br_cnt = 0;
        vs_low = 0;
        ft_cnt = 0;
        ft_first = -1;
        ft_last = -1;
        for (int i = 0; i < 3328; i++) begin
            step(1'b0);
            if (s_br && s_pe) br_cnt++;
            if (!s_vs) vs_low++;
            if (s_ft) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = n;
                ft_last = n;
            end
        end
        chk("frame_bright_pixels", br_cnt, 192);
        chk("frame_vsync_low_clks", vs_low, 512);
`ifdef VGA_FRAME_TICK_EN
        chk("frame_tick_count", ft_cnt, 2);
        chk("frame_tick_spacing", ft_last - ft_first, 1664);
        chk("frame_tick_phase", ft_first % 1664, 1408);
`else
        chk("frame_tick_count", ft_cnt, 0);
`endif

        // Reset for one clock in the middle of a line, then restart from the origin.
        while (!((n / DIV) % 800 == 400 && n % DIV == 0)) step(1'b0);
        chk("pre_rst.h", int'(f_h), 400);
        chk("pre_rst.v", int'(f_v), 4);
        step(1'b1);
        chk("mid_rst.h",  int'(f_h),  0);
        chk("mid_rst.v",  int'(f_v),  0);
        chk("mid_rst.hs", int'(f_hs), 0);
        chk("mid_rst.vs", int'(f_vs), 0);
        chk("mid_rst.br", int'(f_br), 0);
        chk("mid_rst.pe", int'(f_pe), 0);
        chk("mid_rst.ft", int'(f_ft), 0);
        chk("mid_rst.small_h", int'(s_h), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0);
            chk($sformatf("restart%0d.pe", i), int'(f_pe), 0);
            chk($sformatf("restart%0d.h", i),  int'(f_h),  0);
        end
        step(1'b0);
        chk("restart4.pe", int'(f_pe), 1);
        chk("restart4.h",  int'(f_h),  1);
        chk("restart4.v",  int'(f_v),  0);

        @(negedge clk);
        #1;
        chk("sb_full_drained", sb_full.size(), 0);
        chk("sb_small_drained", sb_small.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
